// File: rtl/alu_pkg.sv
// Shared constants and types for the RV32IM ALU sequencer: ctrl bit positions,
// funct3 codes, op classes, FSM states and RISC-V divide corner-case results.
package alu_pkg;

    localparam int CTRL_B30 = 4;
    localparam int CTRL_M   = 3;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        CLS_I   = 2'd0,
        CLS_SLL = 2'd1,
        CLS_MUL = 2'd2,
        CLS_DIV = 2'd3
    } op_cls_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational request decoder: op class, latency count and the divide
// corner cases (by zero, signed overflow) that bypass the ALU.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int SLL_LAT = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic [3:0]       ctrl_i,
    input  logic [31:0]      a_i,
    input  logic [31:0]      b_i,
    output op_cls_e          cls_o,
    output logic [CNT_W-1:0] lat_o,
    output logic             special_o,
    output logic [31:0]      special_y_o
);

    logic b_zero_s;
    logic ovf_s;

    assign b_zero_s  = (b_i == 32'd0);
    assign ovf_s     = !ctrl_i[0] && (a_i == INT_MIN) && (b_i == 32'hFFFF_FFFF);
    assign special_o = b_zero_s || ovf_s;

    // Classify the op and pick how long the ALU needs for it.
    always_comb begin
        cls_o = CLS_I;
        if (ctrl_i[CTRL_M]) begin
            cls_o = ctrl_i[2] ? CLS_DIV : CLS_MUL;
        end else if (ctrl_i[2:0] == F3_SLL) begin
            cls_o = CLS_SLL;
        end else begin
            cls_o = CLS_I;
        end

        case (cls_o)
            CLS_SLL: lat_o = CNT_W'(SLL_LAT);
            CLS_MUL: lat_o = CNT_W'(MUL_LAT);
            CLS_DIV: lat_o = CNT_W'(DIV_LAT);
            default: lat_o = CNT_W'(1);
        endcase
    end

    // RISC-V mandated results; ctrl[1] separates rem/remu from div/divu.
    always_comb begin
        special_y_o = 32'd0;
        if (b_zero_s) begin
            case (ctrl_i[2:0])
                F3_REM, F3_REMU: special_y_o = a_i;
                F3_DIV, F3_DIVU: special_y_o = DIV0_Q;
                default:         special_y_o = DIV0_Q;
            endcase
        end else if (ovf_s) begin
            special_y_o = ctrl_i[1] ? 32'd0 : INT_MIN;
        end else begin
            special_y_o = 32'd0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage controller: accepts one op, holds ALU inputs stable through its
// latency, captures the result and offers it on a valid/ready response port.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SLL_LAT = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_y,
    output logic        rsp_cout,
    output logic        busy,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    output logic        alu_in_en,
    input  logic [31:0] alu_y,
    input  logic        alu_cout
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic [31:0]      y_q, y_d;
    logic             cout_q, cout_d;
    logic             vld_q, vld_d;

    op_cls_e          cls_s;
    logic [CNT_W-1:0] lat_s;
    logic             special_s;
    logic [31:0]      special_y_s;
    logic             fast_path_s;
    logic             accept_s;

    alu_op_decode #(
        .SLL_LAT (SLL_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_decode (
        .ctrl_i      (req_ctrl[3:0]),
        .a_i         (req_a),
        .b_i         (req_b),
        .cls_o       (cls_s),
        .lat_o       (lat_s),
        .special_o   (special_s),
        .special_y_o (special_y_s)
    );

    assign fast_path_s = (cls_s == CLS_DIV) && special_s;
    assign req_ready   = rst_n && (state_q == IDLE) && !flush;
    assign accept_s    = req_valid && req_ready;

    assign busy      = (state_q != IDLE);
    assign alu_in_en = (state_q == ISSUE);
    assign rsp_valid = vld_q;
    assign rsp_y     = y_q;
    assign rsp_cout  = cout_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctrl  = ctrl_q;

    // Next-state logic; flush overrides everything except reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        y_d     = y_q;
        cout_d  = cout_q;
        vld_d   = vld_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = 32'd0;
            cout_d  = 1'b0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        a_d    = req_a;
                        b_d    = req_b;
                        ctrl_d = req_ctrl;
                        if (fast_path_s) begin
                            // Result is known now; rsp_valid follows one cycle later.
                            state_d = DONE;
                            y_d     = special_y_s;
                            cout_d  = 1'b0;
                        end else begin
                            state_d = ISSUE;
                            cnt_d   = lat_s;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ISSUE: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = DONE;
                        y_d     = alu_y;
                        cout_d  = alu_cout;
                        vld_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!vld_q) begin
                        vld_d = 1'b1;
                    end else if (rsp_ready) begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        vld_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            ctrl_q  <= {2'b00, F3_ADD};
            y_q     <= 32'd0;
            cout_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized bench for alu_sequencer with a latency-accurate ALU model that only
// presents the correct result in the cycle the sequencer is due to capture it.
module tb_alu_sequencer;

    localparam int SLL_LAT = 2;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 33;
    localparam int CNT_W   = 6;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_cout;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic        alu_in_en;
    logic [31:0] alu_y;
    logic        alu_cout;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(
        .SLL_LAT (SLL_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_in_en (alu_in_en),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // RV32IM semantics, including the mandated divide corner cases; {cout, y}.
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] c);
        logic [63:0] p;
        logic [31:0] y;
        logic        co;
        logic        ovf;
        p   = 64'd0;
        y   = 32'd0;
        co  = 1'b0;
        ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
        if (!c[3]) begin
            case (c[2:0])
                3'd0: begin
                    if (c[4]) {co, y} = {1'b0, a} + {1'b0, ~b} + 33'd1;
                    else      {co, y} = {1'b0, a} + {1'b0, b};
                end
                3'd1: y = a << b[4:0];
                3'd2: y = {31'd0, ($signed(a) < $signed(b))};
                3'd3: y = {31'd0, (a < b)};
                3'd4: y = a ^ b;
                3'd5: begin
                    if (c[4]) y = $signed(a) >>> b[4:0];
                    else      y = a >> b[4:0];
                end
                3'd6: y = a | b;
                default: y = a & b;
            endcase
        end else begin
            case (c[2:0])
                3'd0: begin p = {32'd0, a} * {32'd0, b}; y = p[31:0]; end
                3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; y = p[63:32]; end
                3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; y = p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; y = p[63:32]; end
                3'd4: begin
                    if (b == 32'd0) y = 32'hFFFF_FFFF;
                    else if (ovf)   y = INT_MIN;
                    else            y = $signed(a) / $signed(b);
                end
                3'd5: begin
                    if (b == 32'd0) y = 32'hFFFF_FFFF;
                    else            y = a / b;
                end
                3'd6: begin
                    if (b == 32'd0) y = a;
                    else if (ovf)   y = 32'd0;
                    else            y = $signed(a) % $signed(b);
                end
                default: begin
                    if (b == 32'd0) y = a;
                    else            y = a % b;
                end
            endcase
        end
        return {co, y};
    endfunction

    function automatic int lat_of(input logic [4:0] c);
        if (!c[3]) return (c[2:0] == 3'd1) ? SLL_LAT : 1;
        else       return c[2] ? DIV_LAT : MUL_LAT;
    endfunction

    function automatic bit is_fast(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] c);
        return c[3] && c[2] &&
               ((b == 32'd0) || (!c[0] && a == INT_MIN && b == 32'hFFFF_FFFF));
    endfunction

    // ALU model: starts at the edge that sees alu_in_en, right result only at its due cycle.
    int   alu_age;
    logic alu_run;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_run <= 1'b0;
            alu_age <= 0;
        end else if (alu_in_en) begin
            alu_run <= 1'b1;
            alu_age <= 0;
        end else if (alu_run) begin
            alu_age <= alu_age + 1;
        end
    end

    logic [32:0] alu_res;
    always_comb begin
        alu_res = ref_alu(alu_a, alu_b, alu_ctrl);
        if (alu_run && alu_age == lat_of(alu_ctrl) - 1) {alu_cout, alu_y} = alu_res;
        else                                            {alu_cout, alu_y} = ~alu_res;
    end

    // One full transaction from IDLE: accept, latency, stall for 'hold' cycles, deliver.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c,
                          input int hold, output logic [31:0] y_o);
        logic [32:0] exp_r;
        int          exp_k;
        bit          fast;
        int          k;
        int          en_cnt;
        bit          b_moved;
        bit          idle_seen;
        bit          unstable;
        logic [31:0] y0;
        exp_r = ref_alu(a, b, c);
        fast  = is_fast(a, b, c);
        exp_k = fast ? 1 : 1 + lat_of(c);
        check_eq("idle_ready", req_ready, 1);
        req_a = a; req_b = b; req_ctrl = c; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0; en_cnt = 0; b_moved = 0; idle_seen = 0;
        while (!rsp_valid && k < 100) begin
            if (alu_in_en) en_cnt++;
            if (alu_b !== b) b_moved = 1;
            if (!busy || req_ready) idle_seen = 1;
            @(posedge clk); #1;
            k++;
        end
        check_eq("rsp_latency", k, exp_k);
        check_eq("in_en_cycles", en_cnt, fast ? 1 - 1 : 1);
        check_eq("alu_b_held", b_moved, 0);
        check_eq("busy_during_op", idle_seen, 0);
        check_eq("rsp_y", rsp_y, exp_r[31:0]);
        check_eq("rsp_cout", rsp_cout, exp_r[32]);
        y0 = rsp_y;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_y !== y0 || !rsp_valid || req_ready || alu_in_en) unstable = 1;
        end
        check_eq("rsp_hold_stable", unstable, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("delivered_valid", rsp_valid, 0);
        check_eq("delivered_busy", busy, 0);
        y_o = y0;
    endtask

    logic [31:0] y;
    logic [31:0] ra, rb;
    logic [4:0]  rc;
    int          cnt;

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = 32'd0; req_b = 32'd0; req_ctrl = 5'd0;
        #3;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_in_en", alu_in_en, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_y", rsp_y, 0);
        check_eq("rst_alu_a", alu_a, 0);
        #9 rst_n = 1'b1;
        #1 check_eq("ready_after_rst", req_ready, 1);
        @(posedge clk); #1;

        run_op(32'd5, 32'd7, 5'b00000, 0, y);
        check_eq("tp_add", y, 32'd12);
        run_op(32'd5, 32'd7, 5'b10000, 0, y);
        check_eq("tp_sub_neg", y, 32'hFFFF_FFFE);
        run_op(32'd7, 32'd5, 5'b10000, 0, y);
        check_eq("tp_sub_pos", y, 32'd2);
        run_op(32'h0000_FFFF, 32'h0001_0001, 5'b01000, 10, y);
        check_eq("tp_mul", y, 32'hFFFF_FFFF);
        run_op(32'd123, 32'd0, 5'b01101, 1, y);
        check_eq("tp_divu0", y, 32'hFFFF_FFFF);
        run_op(INT_MIN, 32'hFFFF_FFFF, 5'b01110, 0, y);
        check_eq("tp_rem_ovf", y, 32'd0);
        run_op(32'd100, 32'd7, 5'b01100, 0, y);
        check_eq("tp_div", y, 32'd14);
        run_op(32'h0000_0003, 32'd4, 5'b00001, 2, y);
        check_eq("tp_sll", y, 32'h30);

        // Flush mid-divide, then flush racing a request in IDLE.
        req_a = 32'd100; req_b = 32'd7; req_ctrl = 5'b01100; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        check_eq("flush_busy", busy, 0);
        check_eq("flush_rsp_valid", rsp_valid, 0);
        req_valid = 1'b1;
        check_eq("flush_blocks_ready", req_ready, 0);
        @(posedge clk); #1;
        check_eq("flush_no_accept", busy, 0);
        flush = 1'b0; req_valid = 1'b0;
        cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (rsp_valid) cnt++; end
        check_eq("flush_no_rsp", cnt, 0);
        run_op(32'd20, 32'd22, 5'b00000, 0, y);
        check_eq("post_flush_add", y, 32'd42);

        // Flush in DONE with rsp_ready high drops the response.
        req_a = 32'd3; req_b = 32'd9; req_ctrl = 5'b01000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin @(posedge clk); #1; cnt++; end
        check_eq("done_flush_lat", cnt, 1 + MUL_LAT);
        flush = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; rsp_ready = 1'b0;
        check_eq("done_flush_valid", rsp_valid, 0);
        check_eq("done_flush_busy", busy, 0);
        check_eq("done_flush_y", rsp_y, 0);

        // Asynchronous reset while the multiply is in ISSUE.
        req_a = 32'd11; req_b = 32'd13; req_ctrl = 5'b01000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("pre_rst_in_en", alu_in_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_rsp_valid", rsp_valid, 0);
        check_eq("arst_in_en", alu_in_en, 0);
        check_eq("arst_ready_low", req_ready, 0);
        check_eq("arst_alu_a", alu_a, 0);
        #2 rst_n = 1'b1;
        #1 check_eq("arst_ready_high", req_ready, 1);
        cnt = 0;
        repeat (10) begin @(posedge clk); #1; if (rsp_valid || busy) cnt++; end
        check_eq("arst_no_rsp", cnt, 0);

        for (int i = 0; i < 80; i++) begin
            rc = 5'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       begin ra = INT_MIN; rb = 32'hFFFF_FFFF; end
                2:       rb = rb & 32'h1F;
                default: rb = rb;
            endcase
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execute-stage controller that sequences the team's 32-bit RV32IM ALU.
- Accepts one operation at a time through a valid/ready request port and drives the ALU operand, control and `in_en` inputs.
- Holds those ALU inputs stable while a multi-cycle operation (left shift, multiply, divide) completes, then captures the result and returns it on a valid/ready response port.
- Resolves RISC-V divide-by-zero and signed-overflow division directly, without using the ALU.

Parameters:
- SLL_LAT, 2: cycles from ALU operand registration to a valid left-shift result.
- MUL_LAT, 4: cycles from ALU operand registration to a valid multiply result.
- DIV_LAT, 33: cycles from ALU operand registration to a valid divide/remainder result.
- CNT_W, 6: latency counter width; must hold max(SLL_LAT, MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of any in-flight operation.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE with flush=0.
- req_a  in  32  operand A.
- req_b  in  32  operand B (register or immediate).
- req_ctrl  in  5  op code: [4]=instr bit30, [3]=instr bit25, [2:0]=funct3.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_y  out  32  result.
- rsp_cout  out  1  adder carry-out; 0 for fast-path results.
- busy  out  1  high whenever state is not IDLE.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_ctrl  out  5  ALU control.
- alu_in_en  out  1  ALU start strobe.
- alu_y  in  32  ALU result.
- alu_cout  in  1  ALU carry-out.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs return to 0, except req_ready, which is 1 once rst_n=1.
  - Reset mid-operation discards the operation; no response is produced.
- Op classes:
  - ctrl[3]=0, ctrl[2:0]=001: SLL, latency SLL_LAT.
  - Any other ctrl[3]=0 code: I, latency 1.
  - ctrl[3]=1, ctrl[2]=0: MUL, latency MUL_LAT.
  - ctrl[3]=1, ctrl[2]=1: DIV, latency DIV_LAT.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE; a fast-path divide goes IDLE -> DONE.
- Accept (IDLE): at the edge where req_valid & req_ready, latch req_a/req_b/req_ctrl into alu_a/alu_b/alu_ctrl.
  - alu_a/alu_b/alu_ctrl stay constant until the next accept. The ALU reads b combinationally for left shift, so alu_b must not move mid-operation.
- ISSUE: lasts exactly one cycle with alu_in_en=1. alu_in_en is 0 in every other state.
- WAIT: counts down; the result is captured (alu_y to rsp_y, alu_cout to rsp_cout) at accept edge + 1 + LAT for the op's class.
- DONE: rsp_valid=1 with rsp_y/rsp_cout stable until the edge where rsp_ready=1, then the block returns to IDLE.
  - req_ready=0 in DONE, so there is no same-cycle re-accept; peak throughput is one op per LAT+3 cycles.
- DIV fast path, decided at accept; the block goes straight to DONE with rsp_valid high after accept edge + 1:
  - b==0: div/divu give 0xFFFFFFFF; rem/remu give a.
  - Signed div/rem (ctrl[0]=0) with a==0x80000000 and b==0xFFFFFFFF: div gives 0x80000000, rem gives 0.
  - divu/remu are never treated as overflow.
- Flush:
  - Highest priority, below reset only.
  - At the next edge: state to IDLE, rsp_valid=0, any captured result dropped.
  - flush together with req_valid in IDLE: no accept (req_ready is 0 while flush=1).
  - flush in DONE with rsp_ready=1: the response is not considered delivered.
- Latency 0 values are illegal; a LAT of 1 is treated as the I-class path.

Decomposition:
- Package alu_pkg holds:
  - ctrl bit-position constants (CTRL_B30=4, CTRL_M=3).
  - funct3 constants (F3_ADD, F3_SLL, F3_DIV, ...).
  - op-class enum {CLS_I, CLS_SLL, CLS_MUL, CLS_DIV}.
  - state enum {IDLE, ISSUE, WAIT, DONE}.
  - constants DIV0_Q=32'hFFFF_FFFF and INT_MIN=32'h8000_0000.
- One sub-module, alu_op_decode: combinational. It maps req_ctrl/req_a/req_b to the op class, the latency count, the fast-path flag and the fast-path result.

Test Plan:
1. add: a=5, b=7, ctrl=00000, accepted at edge 0 -> rsp_valid rises after edge 2, rsp_y=12, rsp_cout=0; alu_in_en high exactly one cycle.
2. sub: a=5, b=7, ctrl=10000 -> rsp_y=0xFFFFFFFE, rsp_cout=0; then a=7, b=5 -> rsp_y=2, rsp_cout=1.
3. mul: a=0xFFFF, b=0x10001, ctrl=01000, MUL_LAT=4 -> rsp_valid after edge 5, rsp_y=0xFFFFFFFF.
   - Hold rsp_ready=0 for 10 cycles -> rsp_y stable and req_ready=0 throughout.
4. div fast path:
   - divu: a=123, b=0, ctrl=01101 -> rsp_valid after edge 1, rsp_y=0xFFFFFFFF.
   - rem: a=0x80000000, b=0xFFFFFFFF, ctrl=01110 -> rsp_y=0.
   - alu_in_en never asserted in either case.
5. div normal: a=100, b=7, ctrl=01100 -> rsp_valid after edge 34, rsp_y=14, with alu_b held at 7 throughout.
   - Assert flush at edge 10 -> IDLE at edge 11, no rsp_valid.
   - A new add issued afterwards returns its correct result.
6. Reset: rst_n=0 mid-MUL, asynchronously -> busy, rsp_valid and alu_in_en go to 0 immediately; req_ready=1 once rst_n is released.
